lane_init_sequencer: RTL
========================

Name: lane_init_sequencer

Overview:
- Sideband-domain link-initialisation controller that sequences the timer block.
- Drives the timer's enables (disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s) and consumes its timeout flags.
- Steps the lane DISABLED -> disconnect -> connect -> Gen4 TS1/TS2 training -> CL0, with bounded retry and error exit.
- Sits between the timer and the logical-layer TS generator/detector.

Parameters:
- SYNC_STAGES, 2, flop stages used to resynchronise clk_b-domain timer flags into sb_clk.
- MAX_RETRIES, 3, TS1/TS2 timeouts tolerated per training attempt before ERROR (range 1..7).

Ports:
- sb_clk  in  1  sideband clock, 1 MHz.
- rst  in  1  reset, asynchronous, active-low.
- lane_en  in  1  lane enable from configuration; level.
- ts1_rcvd  in  1  one-cycle pulse, valid Gen4 TS1 received.
- ts2_rcvd  in  1  one-cycle pulse, valid Gen4 TS2 received.
- tdisconnect_tx_min  in  1  timer flag, clk_b domain.
- tdisabled_min  in  1  timer flag, clk_b domain.
- tgen4_ts1_timeout  in  1  timer flag, clk_b domain.
- tgen4_ts2_timeout  in  1  timer flag, clk_b domain.
- tdisconnect_rx_min  in  1  timer flag, sb_clk domain.
- tconnect_rx_min  in  1  timer flag, sb_clk domain.
- ttraining_error_timeout  in  1  timer flag, sb_clk domain.
- disconnected_s  out  1  to timer; high in DISCONNECT_TX.
- fsm_disabled  out  1  to timer; high in DISABLED.
- fsm_training  out  1  to timer; high in TRAIN_TS1 and TRAIN_TS2.
- ts1_gen4_s  out  1  to timer and TS generator; high in TRAIN_TS1.
- ts2_gen4_s  out  1  to timer and TS generator; high in TRAIN_TS2.
- sbtx_drive  out  1  0 = hold SBTX low, 1 = release SBTX high.
- link_up  out  1  high in CL0.
- training_error  out  1  one-cycle pulse on ERROR entry.
- retry_cnt  out  3  current retry count.
- state  out  3  encoded FSM state, for debug.

Behaviour:
- Reset: state = DISABLED, fsm_disabled = 1, every other output 0, retry_cnt = 0, all sticky flags cleared. Async assert, sync release.
- Output timing: all outputs are registered and decoded from the next state, so they change on the same edge as state. Latency from an sb_clk-domain input to state/output change is 1 cycle.
- clk_b flag handling: each clk_b flag passes through a SYNC_STAGES synchroniser, then a rising-edge detect that sets a sticky "seen" bit. Total latency is SYNC_STAGES+1 cycles.
- Sticky bits clear on every state entry. A flag still high from a previous visit is therefore ignored until it falls and rises again.
- State encoding: DISABLED=0, DISCONNECT_TX=1, WAIT_CONNECT=2, TRAIN_TS1=3, TRAIN_TS2=4, CL0=5, ERROR=6. Code 7 is illegal and goes to DISABLED.
- DISABLED: sbtx_drive = 0, retry_cnt cleared. Go to DISCONNECT_TX when tdisabled_min_seen && lane_en.
- DISCONNECT_TX: sbtx_drive = 0. Go to WAIT_CONNECT on tdisconnect_tx_min_seen. lane_en = 0 -> DISABLED.
- WAIT_CONNECT: sbtx_drive = 1. Go to TRAIN_TS1 on tconnect_rx_min. lane_en = 0 -> DISABLED.
- TRAIN_TS1: go to TRAIN_TS2 on ts1_rcvd; on tgen4_ts1_timeout_seen take the retry path.
- TRAIN_TS2: go to CL0 on ts2_rcvd; on tgen4_ts2_timeout_seen take the retry path.
- Training-state priority (highest first): ttraining_error_timeout -> ERROR; lane_en = 0 -> DISABLED; ts rcvd; ts timeout.
- Retry path: if retry_cnt+1 < MAX_RETRIES, increment retry_cnt and go to DISCONNECT_TX. Otherwise go to ERROR. retry_cnt saturates at MAX_RETRIES.
- CL0: link_up = 1, retry_cnt cleared on entry. Priority: lane_en = 0 -> DISABLED; then tdisconnect_rx_min -> DISCONNECT_TX.
- ERROR: single cycle with training_error = 1 and sbtx_drive = 0, then unconditionally DISABLED.
- fsm_training stays high continuously across the TS1 -> TS2 transition, so the training-error budget spans both states.
- Simultaneous ts1_rcvd and TS1 timeout: rcvd wins. ts2_rcvd arriving in TRAIN_TS1 is ignored.
- rst asserted mid-training: all outputs return to reset values immediately.

Decomposition:
- Package lane_init_pkg: state enum and encoding, STATE_W = 3, RETRY_W = 3.
- One sub-module, flag_sync_edge: SYNC_STAGES-deep synchroniser, rising-edge detect and sticky bit with clear input. Instantiated 4 times, once per clk_b flag.

Test Plan:
- Reset release, lane_en = 1, pulse tdisabled_min for 1 clk_b period -> DISCONNECT_TX after SYNC_STAGES+1 = 3 cycles, disconnected_s = 1, fsm_disabled = 0, sbtx_drive = 0.
- Happy path: tdisconnect_tx_min high, then tconnect_rx_min pulse, then ts1_rcvd, then ts2_rcvd -> state sequence 1,2,3,4,5; link_up = 1 one cycle after ts2_rcvd; fsm_training high continuously through states 3-4.
- Three consecutive tgen4_ts1_timeout rising edges with MAX_RETRIES = 3 -> retry_cnt goes 1, 2, then ERROR with training_error pulse exactly 1 cycle, then DISABLED.
- Stale tdisconnect_tx_min held high across re-entry to DISCONNECT_TX -> no exit until the flag goes low then high again.
- Same cycle ttraining_error_timeout = 1 and ts2_rcvd = 1 in TRAIN_TS2 -> ERROR, not CL0.
- In CL0, tdisconnect_rx_min pulse -> DISCONNECT_TX, link_up = 0. Separately, lane_en = 0 together with tdisconnect_rx_min -> DISABLED.

Source files
------------

// File: rtl/lane_init_pkg.sv
// lane_init_pkg: state encoding and widths shared by the lane init sequencer.
package lane_init_pkg;
   localparam int STATE_W = 3;
   localparam int RETRY_W = 3;
   typedef enum logic [STATE_W-1:0] {
      DISABLED      = 3'd0,
      DISCONNECT_TX = 3'd1,
      WAIT_CONNECT  = 3'd2,
      TRAIN_TS1     = 3'd3,
      TRAIN_TS2     = 3'd4,
      CL0           = 3'd5,
      ERROR         = 3'd6
   } lane_state_e;
endpackage

// File: rtl/flag_sync_edge.sv
// flag_sync_edge: resynchronises a clk_b timer flag into sb_clk and latches its rising edge
// in a sticky bit that the sequencer clears whenever it enters a new state.
module flag_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic sb_clk,
   input  logic rst,
   input  logic flag,
   input  logic clr,
   output logic seen
);
   logic [SYNC_STAGES-1:0] sync;
   logic prev, hit, rise;
   assign rise = sync[SYNC_STAGES-1] & ~prev;
   assign seen = hit | rise;
   always_ff @(posedge sb_clk or negedge rst)
      if (!rst) begin
         sync <= '0;
         prev <= 1'b0;
         hit  <= 1'b0;
      end else begin
         sync <= SYNC_STAGES'({sync, flag});
         prev <= sync[SYNC_STAGES-1];
         hit  <= !clr && seen;
      end
endmodule

// File: rtl/lane_init_sequencer.sv
// lane_init_sequencer: steps a lane from DISABLED through disconnect, connect and Gen4
// TS1/TS2 training into CL0, driving the timer enables and consuming its timeout flags.
module lane_init_sequencer
   import lane_init_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_RETRIES = 3
) (
   input  logic       sb_clk,
   input  logic       rst,
   input  logic       lane_en,
   input  logic       ts1_rcvd,
   input  logic       ts2_rcvd,
   input  logic       tdisconnect_tx_min,
   input  logic       tdisabled_min,
   input  logic       tgen4_ts1_timeout,
   input  logic       tgen4_ts2_timeout,
   input  logic       tdisconnect_rx_min,
   input  logic       tconnect_rx_min,
   input  logic       ttraining_error_timeout,
   output logic       disconnected_s,
   output logic       fsm_disabled,
   output logic       fsm_training,
   output logic       ts1_gen4_s,
   output logic       ts2_gen4_s,
   output logic       sbtx_drive,
   output logic       link_up,
   output logic       training_error,
   output logic [2:0] retry_cnt,
   output logic [2:0] state
);
   lane_state_e cur, nxt;
   logic [RETRY_W-1:0] cnt, nxt_cnt, inc;
   logic [1:0] rst_sync;
   logic rst_n, clr, in_ts1, rcvd, tout;
   logic dis_seen, dtx_seen, ts1_to_seen, ts2_to_seen;
   // reset asserts asynchronously but is released only on a clock edge
   always_ff @(posedge sb_clk or negedge rst)
      if (!rst) rst_sync <= 2'b00;
      else rst_sync <= {rst_sync[0], 1'b1};
   assign rst_n = rst_sync[1];
   assign clr = nxt != cur;
   flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dis (.sb_clk, .rst(rst_n), .flag(tdisabled_min), .clr, .seen(dis_seen));
   flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dtx (.sb_clk, .rst(rst_n), .flag(tdisconnect_tx_min), .clr, .seen(dtx_seen));
   flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ts1 (.sb_clk, .rst(rst_n), .flag(tgen4_ts1_timeout), .clr, .seen(ts1_to_seen));
   flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ts2 (.sb_clk, .rst(rst_n), .flag(tgen4_ts2_timeout), .clr, .seen(ts2_to_seen));
   assign inc    = cnt + 1'b1;
   assign in_ts1 = cur == TRAIN_TS1;
   assign rcvd   = in_ts1 ? ts1_rcvd : ts2_rcvd;
   assign tout   = in_ts1 ? ts1_to_seen : ts2_to_seen;
   always_comb begin
      nxt     = cur;
      nxt_cnt = cnt;
      case (cur)
         DISABLED:      nxt = (dis_seen && lane_en) ? DISCONNECT_TX : DISABLED;
         DISCONNECT_TX: nxt = !lane_en ? DISABLED : dtx_seen ? WAIT_CONNECT : DISCONNECT_TX;
         WAIT_CONNECT:  nxt = !lane_en ? DISABLED : tconnect_rx_min ? TRAIN_TS1 : WAIT_CONNECT;
         TRAIN_TS1, TRAIN_TS2: begin
            if (ttraining_error_timeout) nxt = ERROR;
            else if (!lane_en) nxt = DISABLED;
            else if (rcvd) nxt = in_ts1 ? TRAIN_TS2 : CL0;
            else if (tout) begin
               nxt     = (inc < RETRY_W'(MAX_RETRIES)) ? DISCONNECT_TX : ERROR;
               nxt_cnt = inc;
            end
         end
         CL0:           nxt = !lane_en ? DISABLED : tdisconnect_rx_min ? DISCONNECT_TX : CL0;
         default:       nxt = DISABLED;
      endcase
      if (nxt == DISABLED || nxt == CL0) nxt_cnt = '0;
   end
   always_ff @(posedge sb_clk or negedge rst_n)
      if (!rst_n) begin
         cur            <= DISABLED;
         cnt            <= '0;
         disconnected_s <= 1'b0;
         fsm_disabled   <= 1'b1;
         fsm_training   <= 1'b0;
         ts1_gen4_s     <= 1'b0;
         ts2_gen4_s     <= 1'b0;
         sbtx_drive     <= 1'b0;
         link_up        <= 1'b0;
         training_error <= 1'b0;
      end else begin
         cur            <= nxt;
         cnt            <= nxt_cnt;
         disconnected_s <= nxt == DISCONNECT_TX;
         fsm_disabled   <= nxt == DISABLED;
         fsm_training   <= nxt == TRAIN_TS1 || nxt == TRAIN_TS2;
         ts1_gen4_s     <= nxt == TRAIN_TS1;
         ts2_gen4_s     <= nxt == TRAIN_TS2;
         sbtx_drive     <= nxt == WAIT_CONNECT || nxt == TRAIN_TS1 || nxt == TRAIN_TS2 || nxt == CL0;
         link_up        <= nxt == CL0;
         training_error <= nxt == ERROR;
      end
   assign retry_cnt = cnt;
   assign state     = cur;
endmodule
